// File: rtl/io_poller.sv
`default_nettype none
// ============================================================================
// Module   : io_poller
// Brief    : Periodic io-bus initiator: reads operand/op switch ports, computes
//            an 8-bit result, writes result and operand pair to display ports.
//            Optional macro IO_POLLER_WRITE_ON_CHANGE_EN skips unchanged writes.
// Revision : 1.0 - initial release
// ============================================================================
module io_poller #(
    parameter int POLL_CYCLES = 1000,
    parameter int CNT_W       = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] io_data_in,
    output logic [4:0]  addr,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        busy,
    output logic        pass_done,
    output logic [7:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_RD_OP = 3'd3,
        S_CALC  = 3'd4,
        S_WR0   = 3'd5,
        S_WR1   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMER_LAST = CNT_W'(POLL_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [1:0]       r_op;
    logic [7:0]       r_result;
    logic [1:0]       w_op;
    logic [7:0]       w_result;
    logic             w_skip;
    logic             w_unused_bits;

    // Read data is registered by the io block, so each capture lags its address by one state.
    assign w_op          = io_data_in[1:0];
    assign w_unused_bits = ^{io_data_in[31:4], r_op};

`ifdef IO_POLLER_WRITE_ON_CHANGE_EN
    logic [9:0] r_last;
    logic       r_written;
    // The skip decision needs the op read arriving in CALC, so pass_done in CALC follows io_data_in.
    assign w_skip = (r_state == S_CALC) && r_written && ({w_op, r_b, r_a} == r_last);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_result = 8'h00;
        case (w_op)
            2'b00:   w_result = {4'h0, r_a} + {4'h0, r_b};
            2'b01:   w_result = {4'h0, r_a} - {4'h0, r_b};
            2'b10:   w_result = {4'h0, r_a & r_b};
            default: w_result = {4'h0, r_a ^ r_b};
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable && (r_timer == c_TIMER_LAST)) w_next = S_RD_A;
            S_RD_A:  w_next = S_RD_B;
            S_RD_B:  w_next = S_RD_OP;
            S_RD_OP: w_next = S_CALC;
            S_CALC:  w_next = w_skip ? S_IDLE : S_WR0;
            S_WR0:   w_next = S_WR1;
            S_WR1:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr         = 5'd0;
        data_out     = 32'h0;
        write_enable = 1'b0;
        pass_done    = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_RD_B:  addr = 5'd1;
            S_RD_OP: addr = 5'd2;
            S_CALC:  pass_done = w_skip;
            S_WR0: begin
                write_enable = 1'b1;
                data_out     = {24'h0, r_result};
            end
            S_WR1: begin
                addr         = 5'd1;
                write_enable = 1'b1;
                data_out     = {24'h0, r_b, r_a};
                pass_done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = r_result;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_op     <= 2'b00;
            r_result <= 8'h00;
        end else begin
            r_state <= w_next;
            // Timer only runs in IDLE with enable high; any other condition parks it at zero.
            if ((r_state == S_IDLE) && enable && (r_timer != c_TIMER_LAST))
                r_timer <= r_timer + CNT_W'(1);
            else
                r_timer <= '0;
            if (r_state == S_RD_B)
                r_a <= io_data_in[3:0];
            if (r_state == S_RD_OP)
                r_b <= io_data_in[3:0];
            if (r_state == S_CALC)
                r_op <= w_op;
            if ((r_state == S_CALC) && (w_next == S_WR0))
                r_result <= w_result;
        end
    end

`ifdef IO_POLLER_WRITE_ON_CHANGE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last    <= 10'h0;
            r_written <= 1'b0;
        end else if ((r_state == S_CALC) && !w_skip) begin
            r_last    <= {w_op, r_b, r_a};
            r_written <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
